// File: rtl/bnn_layer_sequencer.sv
// rtl/bnn_layer_sequencer.sv - shares one BNN neuron datapath across N_NEURONS logical neurons
// Optional cumulative issue/wait cycle counter: define BNN_SEQ_PERF_EN.
module bnn_layer_sequencer #(
  parameter int N_NEURONS  = 8,
  parameter int NEURON_LAT = 1,
  parameter int AW         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [7:0]           cfg_wdata,
  input  logic                 start,
  input  logic [7:0]           in_vec,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] out_vec,
  output logic [7:0]           nrn_input,
  output logic [7:0]           nrn_weight,
  output logic                 nrn_valid,
  input  logic                 nrn_result
`ifdef BNN_SEQ_PERF_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);
  localparam logic [AW:0]   N_EXT    = (AW+1)'(N_NEURONS);
  localparam logic [2:0]    LAT3     = 3'(NEURON_LAT);

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [2:0]             wcnt_q, wcnt_d;
  logic [7:0]             in_q, in_d;
  logic [N_NEURONS-1:0]   shadow_q, shadow_d;
  logic [N_NEURONS-1:0]   out_q, out_d;
  logic [7:0]             nin_q, nin_d;
  logic [7:0]             nw_q, nw_d;
  logic [7:0]             wbank_q [N_NEURONS];
  logic                   cfg_ok;

  assign cfg_ok = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_addr} < N_EXT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) wbank_q[i] <= 8'h00;
    end else if (cfg_ok) begin
      wbank_q[cfg_addr] <= cfg_wdata;
    end
  end

  // Neuron operands are driven live during ISSUE and held from the _q copies otherwise.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    in_d       = in_q;
    shadow_d   = shadow_q;
    out_d      = out_q;
    nin_d      = nin_q;
    nw_d       = nw_q;
    nrn_valid  = 1'b0;
    nrn_input  = nin_q;
    nrn_weight = nw_q;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = in_vec;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        nrn_valid  = 1'b1;
        nrn_input  = in_q;
        nrn_weight = wbank_q[idx_q];
        nin_d      = in_q;
        nw_d       = wbank_q[idx_q];
        wcnt_d     = LAT3;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 3'd1) begin
          shadow_d[idx_q] = nrn_result;
          if (idx_q == LAST_IDX) begin
            // Load the result on entry to DONE so it is valid while done is high.
            out_d   = shadow_d;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wcnt_q   <= 3'd0;
      in_q     <= 8'h00;
      shadow_q <= '0;
      out_q    <= '0;
      nin_q    <= 8'h00;
      nw_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      in_q     <= in_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      nin_q    <= nin_d;
      nw_q     <= nw_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign out_vec = out_q;

`ifdef BNN_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= 16'h0000;
    end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'h0001;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
